// File: rtl/mdu_pkg.sv
// Shared op encoding, FSM state type and small decode helpers for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step, WIDTH steps per divide.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH:0]   trial;

  // A borrow out of the trial subtraction means the divisor did not fit this step.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
    end else if (step) begin
      if (trial[WIDTH]) begin
        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_d = trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers; one operand bit per CALC cycle.
// Signed MULT/DIV only when MDU_SIGNED_EN is defined; otherwise every op is unsigned.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d, div0_q, div0_d;
  logic               done_q, done_d, div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, acc_q, acc_d, mplr_q, mplr_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem, quo_fix, rem_fix;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic               accept, start_div0;
  op_e                op_in;

  assign op_in      = op_e'(op);
  assign accept     = start && (state_q == S_IDLE || state_q == S_DONE);
  assign start_div0 = op_is_div(op_in) && (b == '0);

`ifdef MDU_SIGNED_EN
  logic a_neg, b_neg, qneg_q, qneg_d, rneg_q, rneg_d;

  assign a_neg  = op_is_signed(op_in) & a[WIDTH-1];
  assign b_neg  = op_is_signed(op_in) & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign qneg_d = accept ? (a_neg ^ b_neg) : qneg_q;
  assign rneg_d = accept ? a_neg : rneg_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end

  // Remainder follows the dividend's sign so quotient truncates toward zero.
  assign prod_fix = qneg_q ? -prod : prod;
  assign quo_fix  = qneg_q ? -quo : quo;
  assign rem_fix  = rneg_q ? -rem : rem;
`else
  assign a_mag    = a;
  assign b_mag    = b;
  assign prod_fix = prod;
  assign quo_fix  = quo;
  assign rem_fix  = rem;
`endif

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .step      (state_q == S_CALC && is_div_q),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem)
  );

  // Shift-add multiply: the multiplier register fills with low product bits as it drains.
  assign sum  = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
  assign prod = {acc_q, mplr_q};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = start_div0 ? S_FIX : S_CALC;
        else       state_d = S_IDLE;
      end
      S_CALC:  if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_CALC) || (state_q == S_FIX);
  end

  always_comb begin
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    div0_d     = div0_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    mplr_d     = mplr_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = (state_q == S_DONE);
    div_zero_d = div_zero_q;
    if (accept) begin
      cnt_d    = '0;
      is_div_d = op_is_div(op_in);
      div0_d   = start_div0;
      mcand_d  = a_mag;
      acc_d    = '0;
      mplr_d   = b_mag;
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q + CW'(1);
      if (!is_div_q) begin
        acc_d  = sum[WIDTH:1];
        mplr_d = {sum[0], mplr_q[WIDTH-1:1]};
      end
    end else if (state_q == S_FIX && !div0_q) begin
      if (is_div_q) begin
        hi_d = rem_fix;
        lo_d = quo_fix;
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end
    // The flag rises with done even if a new start is taken in that same DONE cycle.
    if (state_q == S_DONE && div0_q) div_zero_d = 1'b1;
    else if (accept)                 div_zero_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      div0_q     <= 1'b0;
      mcand_q    <= '0;
      acc_q      <= '0;
      mplr_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      div0_q     <= div0_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      mplr_q     <= mplr_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and HI/LO width; legal values are 8 to 64, even.
REQ-002 SHALL have port clock, input, 1 bit; the single clock, and all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit; operation request, sampled only while busy=0.
REQ-005 SHALL have port op, input, 2 bits; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports a and b, input, WIDTH bits each; a is the multiplicand/dividend and b is the multiplier/divisor.
REQ-007 SHALL have port busy, output, 1 bit; high in CALC and FIX.
REQ-008 SHALL have port done, output, 1 bit; one-cycle result-valid pulse.
REQ-009 SHALL have ports hi and lo, output, WIDTH bits each; the HI/LO result registers.
REQ-010 SHALL have port div_zero, output, 1 bit; asserted with done when a divide had b=0.

Function
REQ-011 SHALL implement FSM IDLE -> CALC -> FIX -> DONE -> IDLE; busy=0 in IDLE and DONE.
REQ-012 SHALL, on a start accepted at edge k, latch op, a and b, and enter CALC; a and b may change after edge k.
REQ-013 SHALL stay in CALC exactly WIDTH cycles: one shift-add (multiply) or restoring-subtract (divide) step per cycle, with an internal step counter.
REQ-014 SHALL, in FIX, apply sign correction and write hi/lo; done=1 for exactly the cycle after edge k+WIDTH+2.
REQ-015 SHALL produce for MULT/MULTU {hi,lo} = the full 2*WIDTH-bit product, signed or unsigned.
REQ-016 SHALL produce for DIV/DIVU lo = quotient and hi = remainder; signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-017 SHALL, for DIV with a=most-negative and b=-1, give lo=a and hi=0 with no flag.
REQ-018 SHALL, for DIV/DIVU with b=0, go IDLE->FIX->DONE (done after edge k+2), set div_zero=1 with done, and leave hi/lo unchanged.
REQ-019 SHALL clear div_zero at the next accepted start.
REQ-020 SHALL hold hi/lo stable between results.
REQ-021 SHALL ignore start while busy=1.
REQ-022 SHALL accept a start arriving in DONE, launching the next operation; done still pulses for the finished one.

Reset
REQ-023 SHALL, while reset=0, force state IDLE, counter 0, busy=0, done=0, div_zero=0, hi=0 and lo=0.
REQ-024 SHALL, when reset asserts mid-operation, abort the operation with no result written.
REQ-025 SHALL treat the first start as sampled at the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL, with macro MDU_SIGNED_EN defined, implement signed MULT/DIV per REQ-015..017.
REQ-027 SHALL, without MDU_SIGNED_EN, omit the sign logic and treat op 00 as MULTU and op 10 as DIVU; timing is unchanged.

Structure
REQ-028 SHALL take the op encoding and FSM state typedef from package mdu_pkg.
REQ-029 SHALL implement the divide datapath, remainder/quotient shift registers, in sub-module mdu_divider; the multiply datapath and FSM stay in the top module.

Verification (WIDTH=32 unless stated; k = start edge)
REQ-030 SHALL check MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, with done only in the cycle after edge k+34.
REQ-031 SHALL check MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-032 SHALL check DIVU 5/0 after a prior result R -> done after edge k+2, div_zero=1, hi/lo=R; the next start clears div_zero.
REQ-033 SHALL check reset=0 at CALC cycle 10, then start DIVU 100/7 -> outputs zero during reset, busy low, no done, then lo=14, hi=2.
REQ-034 SHALL check a start during busy being ignored, and a start in the DONE cycle giving a second done WIDTH+2 edges later.
REQ-035 SHALL check WIDTH=8: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after edge k+10; without MDU_SIGNED_EN, op 00 on 0xFF*0x02 -> hi=0x01, lo=0xFE.
